// File: rtl/button_debounce.sv
// Switch debouncer: a new input level must hold for STABLE_CYCLES samples before d_out follows.
// Optional DEBOUNCE_SYNC_EN adds a two-flop input synchronizer ahead of the FSM.
module button_debounce #(
  parameter int STABLE_CYCLES = 4,
  parameter int BOUNCE_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                din,
  output logic                d_out,
  output logic                rise,
  output logic                fall,
  output logic                pending,
  output logic [BOUNCE_W-1:0] bounce_cnt
);
  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                d_nxt, rise_nxt, fall_nxt, bounce_inc;
  logic [BOUNCE_W-1:0] bounce_nxt;
  logic                s;

`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], din};
  end
  assign s = sync_q[1];
`else
  assign s = din;
`endif

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    d_nxt      = d_out;
    rise_nxt   = 1'b0;
    fall_nxt   = 1'b0;
    bounce_inc = 1'b0;
    case (state)
      STABLE_LOW: begin
        if (s) begin
          state_nxt = PEND_HIGH;
          cnt_nxt   = CNT_W'(1);
        end
      end
      PEND_HIGH: begin
        if (!s) begin
          state_nxt  = STABLE_LOW;
          cnt_nxt    = '0;
          bounce_inc = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_HIGH;
          cnt_nxt   = '0;
          d_nxt     = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          state_nxt = PEND_LOW;
          cnt_nxt   = CNT_W'(1);
        end
      end
      PEND_LOW: begin
        if (s) begin
          state_nxt  = STABLE_HIGH;
          cnt_nxt    = '0;
          bounce_inc = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_LOW;
          cnt_nxt   = '0;
          d_nxt     = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = STABLE_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Abort counter sticks at all ones instead of wrapping.
  assign bounce_nxt = (bounce_inc && (bounce_cnt != '1)) ? bounce_cnt + BOUNCE_W'(1) : bounce_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= STABLE_LOW;
      cnt        <= '0;
      d_out      <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      bounce_cnt <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      d_out      <= d_nxt;
      rise       <= rise_nxt;
      fall       <= fall_nxt;
      bounce_cnt <= bounce_nxt;
    end
  end

  assign pending = (state == PEND_HIGH) || (state == PEND_LOW);

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed vector table, hand-written corner sequences and
// randomized bouncing input checked against a run-length reference model.
module tb_button_debounce;
  localparam int N = 4;
`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0, rst = 1'b1, din = 1'b0;
  always #5 clk = ~clk;

  logic       d_out, rise, fall, pending;
  logic [7:0] bounce_cnt;
  logic       s_d_out, s_rise, s_fall, s_pending;
  logic [1:0] s_bounce_cnt;

  button_debounce #(.STABLE_CYCLES(N), .BOUNCE_W(8)) dut (
    .clk(clk), .rst(rst), .din(din), .d_out(d_out), .rise(rise), .fall(fall),
    .pending(pending), .bounce_cnt(bounce_cnt));

  button_debounce #(.STABLE_CYCLES(N), .BOUNCE_W(2)) dut_sat (
    .clk(clk), .rst(rst), .din(din), .d_out(s_d_out), .rise(s_rise), .fall(s_fall),
    .pending(s_pending), .bounce_cnt(s_bounce_cnt));

  int checks = 0, errors = 0;

  // Reference model: debounced level plus length of the current run of samples that disagree with it.
  logic m_d = 1'b0, m_r = 1'b0, m_f = 1'b0;
  int   m_run = 0, m_bn = 0;
`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] m_dly = 2'b00;
`endif

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic i);
    logic smp;
    m_r = 1'b0;
    m_f = 1'b0;
    if (r) begin
      m_d = 1'b0; m_run = 0; m_bn = 0;
`ifdef DEBOUNCE_SYNC_EN
      m_dly = 2'b00;
`endif
    end else begin
`ifdef DEBOUNCE_SYNC_EN
      smp   = m_dly[1];
      m_dly = {m_dly[0], i};
`else
      smp = i;
`endif
      if (smp != m_d) begin
        m_run++;
        if (m_run == N) begin
          m_d = smp; m_r = smp; m_f = !smp; m_run = 0;
        end
      end else begin
        if (m_run > 0) m_bn++;
        m_run = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic i);
    logic [7:0] b8, b2;
    rst = r;
    din = i;
    @(posedge clk);
    model_step(r, i);
    #1;
    b8 = (m_bn > 255) ? 8'd255 : 8'(m_bn);
    b2 = (m_bn > 3) ? 8'd3 : 8'(m_bn);
    chk("mdl_d_out", d_out, m_d);
    chk("mdl_rise", rise, m_r);
    chk("mdl_fall", fall, m_f);
    chk("mdl_pending", pending, m_run > 0);
    chk("mdl_bounce", bounce_cnt, b8);
    chk("mdl_sat_bounce", s_bounce_cnt, b2);
    chk("mdl_sat_d_out", s_d_out, m_d);
    chk("rise_fall_excl", rise & fall, 1'b0);
  endtask

  typedef struct {
    logic r, i, d, ri, fa, p;
    logic [7:0] b;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int n, input logic r, input logic i, input logic d,
                     input logic ri, input logic fa, input logic p, input logic [7:0] b);
    vec_t v;
    v.r = r; v.i = i; v.d = d; v.ri = ri; v.fa = fa; v.p = p; v.b = b;
    repeat (n) tbl.push_back(v);
  endtask

  initial begin
    int hold;
    logic lvl;
    // reset with din high, then qualify high, then fall, then bounce pattern 1,1,0,1,1,1,1, then glitch
    add(2, 1, 1, 0, 0, 0, 0, 0);
    add(3, 0, 1, 0, 0, 0, 1, 0);
    add(1, 0, 1, 1, 1, 0, 0, 0);
    add(2, 0, 1, 1, 0, 0, 0, 0);
    add(3, 0, 0, 1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 1, 0, 0);
    add(2, 0, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1);
    add(3, 0, 1, 0, 0, 0, 1, 1);
    add(1, 0, 1, 1, 1, 0, 0, 1);
    add(1, 0, 0, 1, 0, 0, 1, 1);
    add(1, 0, 1, 1, 0, 0, 0, 2);

`ifndef DEBOUNCE_SYNC_EN
    foreach (tbl[k]) begin
      step(tbl[k].r, tbl[k].i);
      chk($sformatf("tbl%0d_d_out", k), d_out, tbl[k].d);
      chk($sformatf("tbl%0d_rise", k), rise, tbl[k].ri);
      chk($sformatf("tbl%0d_fall", k), fall, tbl[k].fa);
      chk($sformatf("tbl%0d_pending", k), pending, tbl[k].p);
      chk($sformatf("tbl%0d_bounce", k), bounce_cnt, tbl[k].b);
    end
`endif

    // five aborted qualifications: wide counter reads 5, 2-bit counter saturates at 3
    step(1, 0); step(1, 0);
    repeat (5) begin step(0, 1); step(0, 0); end
    step(0, 0); step(0, 0);
    chk("sat_bounce_w8", bounce_cnt, 8'd5);
    chk("sat_bounce_w2", s_bounce_cnt, 2'd3);
    chk("sat_d_out", d_out, 1'b0);

    // latency from reset release with din held high
    step(1, 0); step(1, 0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 1);
      chk($sformatf("lat_e%0d_d_out", k), d_out, k >= N + LAT);
      chk($sformatf("lat_e%0d_rise", k), rise, k == N + LAT);
    end

    // randomized bouncing: runs of random length with occasional resets
    step(1, 0);
    lvl = 1'b0;
    for (int c = 0; c < 3000; c += hold) begin
      hold = $urandom_range(1, 6);
      lvl  = ~lvl;
      for (int j = 0; j < hold; j++)
        step(($urandom_range(0, 299) == 0), lvl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive sampling edges a new input level must hold before it is accepted; legal range 2..255.
REQ-002 The block SHALL have parameter BOUNCE_W, default 8, meaning the width of the bounce counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port din, input, 1 bit: raw, possibly bouncing level from a switch or pin.
REQ-006 The block SHALL have port d_out, output, 1 bit: debounced level, registered, intended to drive the d input of the downstream D flip-flop stage.
REQ-007 The block SHALL have port rise, output, 1 bit: one-cycle pulse when d_out goes 0->1.
REQ-008 The block SHALL have port fall, output, 1 bit: one-cycle pulse when d_out goes 1->0.
REQ-009 The block SHALL have port pending, output, 1 bit: high while a candidate level change is being qualified.
REQ-010 The block SHALL have port bounce_cnt, output, BOUNCE_W bits: saturating count of aborted qualifications.

Function
REQ-011 Sample s SHALL be din directly, or the synchronized din per REQ-027; all decisions SHALL be registered.
REQ-012 FSM states SHALL be STABLE_LOW, PEND_HIGH, STABLE_HIGH and PEND_LOW, with an internal counter cnt of ceil(log2(STABLE_CYCLES)) bits.
REQ-013 In STABLE_LOW with s=1, the FSM SHALL go to PEND_HIGH with cnt<=1; with s=0 it SHALL hold.
REQ-014 In PEND_HIGH with s=1 and cnt==STABLE_CYCLES-1, the FSM SHALL go to STABLE_HIGH with d_out<=1, rise<=1 and cnt<=0.
REQ-015 In PEND_HIGH with s=1 and cnt<STABLE_CYCLES-1, cnt SHALL increment.
REQ-016 In PEND_HIGH with s=0, the FSM SHALL return to STABLE_LOW with cnt<=0, increment bounce_cnt, and leave d_out unchanged.
REQ-017 STABLE_HIGH and PEND_LOW SHALL mirror REQ-013..REQ-016 with levels inverted, producing fall instead of rise.
REQ-018 Latency: d_out SHALL change on the STABLE_CYCLES-th consecutive edge that samples the new level (STABLE_CYCLES=4: s high at edges 1..4 -> d_out=1 after edge 4).
REQ-019 rise and fall SHALL each be high for exactly one cycle coincident with the d_out change, and SHALL never both be high.
REQ-020 pending SHALL equal 1 exactly in the PEND_HIGH and PEND_LOW states.
REQ-021 bounce_cnt SHALL saturate at all ones and never wrap.
REQ-022 A single-cycle glitch SHALL never reach d_out, rise or fall.

Reset
REQ-023 When rst=1 at posedge clk, the block SHALL force the state to STABLE_LOW and cnt to 0.
REQ-024 The same reset SHALL force d_out=0, rise=0, fall=0, pending=0 and bounce_cnt=0, and clear the synchronizer flops.
REQ-025 rst SHALL take priority over all transitions; a reset during PEND_* SHALL discard the qualification without incrementing bounce_cnt.
REQ-026 In the first cycle after rst deasserts, the FSM SHALL resume sampling from STABLE_LOW.

Configuration
REQ-027 With DEBOUNCE_SYNC_EN defined, s SHALL be din passed through a two-flop synchronizer, adding exactly 2 cycles to REQ-018 latency.
REQ-028 Without DEBOUNCE_SYNC_EN, s SHALL be din and no synchronizer flops SHALL exist.

Verification (STABLE_CYCLES=4, DEBOUNCE_SYNC_EN undefined unless stated)
REQ-029 A bench SHALL check: rst=1 for 2 cycles, din=1 throughout -> d_out, rise, fall, pending and bounce_cnt all 0 during reset; d_out=1 on the 4th edge after release.
REQ-030 A bench SHALL check: din=1 held 6 cycles from STABLE_LOW -> pending=1 for edges 1..3, rise=1 for one cycle at edge 4, d_out=1 thereafter.
REQ-031 A bench SHALL check: din pattern 1,1,0,1,1,1,1 -> bounce_cnt=1, d_out=1 only after the 7th edge, exactly one rise pulse.
REQ-032 A bench SHALL check: from STABLE_HIGH, din=0 for 4 cycles -> fall=1 for one cycle at edge 4, d_out=0.
REQ-033 A bench SHALL check: with BOUNCE_W=2, 5 aborted qualifications -> bounce_cnt=3 (saturated).
REQ-034 A bench SHALL check: with DEBOUNCE_SYNC_EN, din=1 held -> d_out=1 on the 6th edge.
